// File: rtl/intpol2_d4_pkg.sv
// Shared encodings and widths for the intpol2_D4 control unit.
// The state values are also what state_o exposes for debug.
package intpol2_d4_pkg;

    localparam int STATE_WIDTH   = 3;
    localparam int LAT_CNT_WIDTH = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLR       = 3'd1,
        LD_COEF   = 3'd2,
        WAIT_DATA = 3'd3,
        RD        = 3'd4,
        PIPE      = 3'd5,
        WR        = 3'd6,
        FINISH    = 3'd7
    } state_e;

endpackage

// File: rtl/intpol2_d4_lat_cnt.sv
// Loadable down-counter that times the datapath latency between a read and its write.
// It saturates at zero, so holding the decrement enable at zero is harmless.
module intpol2_d4_lat_cnt
    import intpol2_d4_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     load_i,
    input  logic [LAT_CNT_WIDTH-1:0] load_val_i,
    input  logic                     dec_i,
    output logic                     zero_o
);

    logic [LAT_CNT_WIDTH-1:0] count_q;
    logic [LAT_CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - LAT_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/intpol2_d4_ctrl_fsm.sv
// Run sequencer for the intpol2_D4 interpolator: clear, load three coefficients,
// then read / wait PIPE_LAT cycles / write for each sample until the last one.
module intpol2_d4_ctrl_fsm #(
    parameter int PIPE_LAT    = 3,
    parameter int STATE_WIDTH = intpol2_d4_pkg::STATE_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   Empty,
    input  logic                   Afull,
    input  logic                   comp_addr,
    input  logic                   comp_cnt,
    output logic                   clear,
    output logic                   en_M_addr,
    output logic                   Read_Enable,
    output logic                   en_sum,
    output logic                   Write_Enable,
    output logic                   busy,
    output logic                   done,
    output logic [STATE_WIDTH-1:0] state_o
);
    import intpol2_d4_pkg::*;

    state_e state_q;
    state_e state_d;
    logic   lat_zero;
    logic   lat_load;
    logic   lat_dec;
    logic   write_ok;

    assign write_ok = (state_q == WR) && !Afull;
    assign lat_load = (state_q == RD);
    assign lat_dec  = (state_q == PIPE);

    intpol2_d4_lat_cnt u_lat_cnt (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (lat_load),
        .load_val_i (LAT_CNT_WIDTH'(PIPE_LAT - 1)),
        .dec_i      (lat_dec),
        .zero_o     (lat_zero)
    );

    // Abort only cancels an active run; a write coinciding with it is still issued
    // because the strobes below are decoded from the current state.
    always_comb begin
        state_d = state_q;
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      if (start) state_d = CLR;
                CLR:       state_d = LD_COEF;
                LD_COEF:   if (comp_addr) state_d = WAIT_DATA;
                WAIT_DATA: if (!Empty) state_d = RD;
                RD:        state_d = PIPE;
                PIPE:      if (lat_zero) state_d = WR;
                WR:        if (!Afull) state_d = comp_cnt ? FINISH : WAIT_DATA;
                FINISH:    state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign clear        = (state_q == CLR);
    assign en_M_addr    = (state_q == LD_COEF) && !comp_addr;
    assign Read_Enable  = (state_q == RD);
    assign Write_Enable = write_ok;
    assign en_sum       = write_ok;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == FINISH);
    assign state_o      = STATE_WIDTH'(state_q);

endmodule

// File: tb/tb_intpol2_d4_ctrl_fsm.sv
// Bench for intpol2_d4_ctrl_fsm: two instances (PIPE_LAT=3 and 1) share one stimulus
// timeline; a run-level schedule model predicts every cycle of both.
module tb_intpol2_d4_ctrl_fsm;
    import intpol2_d4_pkg::*;

    localparam int N     = 1200;
    localparam int LAT_A = 3;
    localparam int LAT_B = 1;

    // {clear, en_M_addr, Read_Enable, en_sum, Write_Enable, busy, done}
    localparam logic [6:0] O_IDLE = 7'b0000000;
    localparam logic [6:0] O_CLR  = 7'b1000010;
    localparam logic [6:0] O_ADDR = 7'b0100010;
    localparam logic [6:0] O_RD   = 7'b0010010;
    localparam logic [6:0] O_WR   = 7'b0001110;
    localparam logic [6:0] O_BUSY = 7'b0000010;
    localparam logic [6:0] O_DONE = 7'b0000011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, abort, Empty, Afull, forceAddr;
    int   ilen;

    logic       compAddrA, compCntA, clearA, enMA, reA, enSumA, weA, busyA, doneA;
    logic [2:0] stateA;
    logic       compAddrB, compCntB, clearB, enMB, reB, enSumB, weB, busyB, doneB;
    logic [2:0] stateB;
    int addrCntA, sampCntA, addrCntB, sampCntB;

    bit startV [N];
    bit abortV [N];
    bit rstV   [N];
    bit emptyV [N];
    bit afullV [N];
    bit forceV [N];
    int ilenV  [N];
    logic [9:0] expT [2][N];

    int checks   = 0;
    int failures = 0;

    intpol2_d4_ctrl_fsm #(.PIPE_LAT(LAT_A), .STATE_WIDTH(3)) dutA (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .Empty(Empty), .Afull(Afull),
        .comp_addr(compAddrA), .comp_cnt(compCntA), .clear(clearA), .en_M_addr(enMA),
        .Read_Enable(reA), .en_sum(enSumA), .Write_Enable(weA), .busy(busyA),
        .done(doneA), .state_o(stateA)
    );

    intpol2_d4_ctrl_fsm #(.PIPE_LAT(LAT_B), .STATE_WIDTH(3)) dutB (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .Empty(Empty), .Afull(Afull),
        .comp_addr(compAddrB), .comp_cnt(compCntB), .clear(clearB), .en_M_addr(enMB),
        .Read_Enable(reB), .en_sum(enSumB), .Write_Enable(weB), .busy(busyB),
        .done(doneB), .state_o(stateB)
    );

    // Stand-in for the downstream address/counter block of each instance.
    always @(posedge clk) begin
        if (rst || clearA) begin
            addrCntA <= 0;
            sampCntA <= 0;
        end else begin
            if (enMA) addrCntA <= addrCntA + 1;
            if (enSumA) sampCntA <= sampCntA + 1;
        end
        if (rst || clearB) begin
            addrCntB <= 0;
            sampCntB <= 0;
        end else begin
            if (enMB) addrCntB <= addrCntB + 1;
            if (enSumB) sampCntB <= sampCntB + 1;
        end
    end

    assign compAddrA = forceAddr || (addrCntA == 3);
    assign compCntA  = (sampCntA == ilen - 1);
    assign compAddrB = forceAddr || (addrCntB == 3);
    assign compCntB  = (sampCntB == ilen - 1);

    task automatic emit(input int idx, inout int p, inout bit alive,
                        input state_e st, input logic [6:0] outs);
        if (!alive) return;
        if (p >= N) begin
            alive = 0;
            return;
        end
        expT[idx][p] = {st, outs};
        if (rstV[p] || abortV[p]) alive = 0;
        p++;
    endtask

    // Walks the timeline run by run: each run is a fixed phase schedule stretched
    // by Empty/Afull stalls and cut short by rst or abort.
    task automatic buildModel(input int idx, input int lat);
        int t, p, nAddr;
        bit alive;
        for (int i = 0; i < N; i++) expT[idx][i] = {IDLE, O_IDLE};
        t = 0;
        while (t < N) begin
            if (!startV[t] || rstV[t]) begin
                t++;
                continue;
            end
            p     = t + 1;
            alive = 1;
            nAddr = forceV[t] ? 0 : 3;
            emit(idx, p, alive, CLR, O_CLR);
            for (int i = 0; i < nAddr; i++) emit(idx, p, alive, LD_COEF, O_ADDR);
            emit(idx, p, alive, LD_COEF, O_BUSY);
            for (int smp = 0; smp < ilenV[t]; smp++) begin
                while (alive && p < N && emptyV[p]) emit(idx, p, alive, WAIT_DATA, O_BUSY);
                emit(idx, p, alive, WAIT_DATA, O_BUSY);
                emit(idx, p, alive, RD, O_RD);
                for (int j = 0; j < lat; j++) emit(idx, p, alive, PIPE, O_BUSY);
                while (alive && p < N && afullV[p]) emit(idx, p, alive, WR, O_BUSY);
                emit(idx, p, alive, WR, O_WR);
            end
            emit(idx, p, alive, FINISH, O_DONE);
            t = p;
        end
    endtask

    task automatic setRange(input int lo, input int hi, input int kind, input int val);
        for (int k = lo; k <= hi; k++) begin
            case (kind)
                0: startV[k] = (val != 0);
                1: abortV[k] = (val != 0);
                2: rstV[k]   = (val != 0);
                3: emptyV[k] = (val != 0);
                4: afullV[k] = (val != 0);
                5: forceV[k] = (val != 0);
                default: ilenV[k] = val;
            endcase
        end
    endtask

    task automatic applyStimulus(input int k);
        rst       = rstV[k];
        start     = startV[k];
        abort     = abortV[k];
        Empty     = emptyV[k];
        Afull     = afullV[k];
        forceAddr = forceV[k];
        ilen      = ilenV[k];
    endtask

    task automatic checkOutput(input int idx, input int k, input logic [9:0] obs);
        string tag;
        tag = (idx == 0) ? "lat3" : "lat1";
        checks++;
        assert (obs === expT[idx][k]) else begin
            failures++;
            $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, k, obs, expT[idx][k]);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; Empty = 1'b0; Afull = 1'b0;
        forceAddr = 1'b0; ilen = 4;

        for (int k = 0; k < N; k++) begin
            startV[k] = 0; abortV[k] = 0; rstV[k] = 0;
            emptyV[k] = 0; afullV[k] = 0; forceV[k] = 0; ilenV[k] = 4;
        end

        // Reset, then a plain four-sample run.
        setRange(0, 1, 2, 1);
        setRange(5, 5, 0, 1);
        // Backpressure: output FIFO almost full across the first write slot.
        setRange(60, 119, 6, 3);
        setRange(60, 60, 0, 1);
        setRange(71, 75, 4, 1);
        // Starvation: input FIFO empty for ten cycles of WAIT_DATA.
        setRange(120, 179, 6, 2);
        setRange(120, 120, 0, 1);
        setRange(126, 135, 3, 1);
        // Abort inside PIPE of the second sample, then restart.
        setRange(180, 180, 0, 1);
        setRange(195, 195, 1, 1);
        setRange(200, 259, 6, 2);
        setRange(200, 200, 0, 1);
        // Reset during coefficient load.
        setRange(260, 279, 6, 3);
        setRange(260, 260, 0, 1);
        setRange(263, 263, 2, 1);
        // Single-sample run with the coefficient address already at its limit.
        setRange(280, 309, 6, 1);
        setRange(280, 309, 5, 1);
        setRange(282, 282, 0, 1);
        // start held high: back-to-back runs.
        setRange(310, 429, 6, 2);
        setRange(310, 389, 0, 1);
        // Random traffic.
        setRange(430, N - 1, 6, 3);
        for (int k = 430; k < N; k++) begin
            startV[k] = ($urandom_range(0, 9) == 0);
            emptyV[k] = ($urandom_range(0, 9) < 3);
            afullV[k] = ($urandom_range(0, 9) < 2);
            abortV[k] = !startV[k] && ($urandom_range(0, 99) < 2);
            rstV[k]   = ($urandom_range(0, 199) == 0);
        end

        buildModel(0, LAT_A);
        buildModel(1, LAT_B);

        repeat (2) @(posedge clk);
        for (int k = 0; k < N; k++) begin
            #1 applyStimulus(k);
            @(negedge clk);
            checkOutput(0, k, {stateA, clearA, enMA, reA, enSumA, weA, busyA, doneA});
            checkOutput(1, k, {stateB, clearB, enMB, reB, enSumB, weB, busyB, doneB});
            @(posedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
